// File: rtl/pipe_reg_usage_decoder.sv
// Register-usage decoder for the 5-stage MIPS pipeline: ID source-read enables plus
// a shadow pipeline of EXE/MEM/WB instruction words decoded into destinations and write enables.
module pipe_reg_usage_decoder #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_id,
    input  logic        stall,
    input  logic        flush,
    output logic        re1_id,
    output logic        re2_id,
    output logic [4:0]  ws_exe,
    output logic        we_exe,
    output logic        we_bypass_exe,
    output logic        we_stall_exe,
    output logic [4:0]  ws_mem,
    output logic        we_mem,
    output logic [4:0]  ws_wb,
    output logic        we_wb,
    output logic [31:0] instr_exe,
    output logic [31:0] instr_mem,
    output logic [31:0] instr_wb
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // alu_wr results can be forwarded out of EXE; late_wr results (lw, jal) cannot.
    typedef struct packed {
        logic [4:0] ws;
        logic       alu_wr;
        logic       late_wr;
    } dest_t;

    function automatic dest_t decode_dest(input logic [31:0] instr);
        dest_t d;
        d = '0;
        case (instr[31:26])
            OP_RTYPE: begin
                if (instr[5:0] != FN_JR) begin
                    d.ws     = instr[15:11];
                    d.alu_wr = 1'b1;
                end
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                d.ws     = instr[20:16];
                d.alu_wr = 1'b1;
            end
            OP_LW: begin
                d.ws      = instr[20:16];
                d.late_wr = 1'b1;
            end
            OP_JAL: begin
                d.ws      = RA_REG;
                d.late_wr = 1'b1;
            end
            default: d = '0;
        endcase
        // $0 is hardwired, so writing it is never a real write
        if (d.ws == 5'd0) begin
            d.alu_wr  = 1'b0;
            d.late_wr = 1'b0;
        end
        return d;
    endfunction

    always_comb begin
        re1_id = 1'b0;
        re2_id = 1'b0;
        case (instr_id[31:26])
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: begin
                re1_id = 1'b1;
                re2_id = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: re1_id = 1'b1;
            OP_J, OP_JAL: begin
                re1_id = 1'b0;
                re2_id = 1'b0;
            end
            default: begin
                re1_id = 1'b0;
                re2_id = 1'b0;
            end
        endcase
    end

    // A zero word is a nop, so bubbles and reset both leave the stage writing nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_exe <= '0;
            instr_mem <= '0;
            instr_wb  <= '0;
        end else begin
            instr_exe <= (stall | flush) ? 32'd0 : instr_id;
            instr_mem <= instr_exe;
            instr_wb  <= instr_mem;
        end
    end

    dest_t d_exe, d_mem, d_wb;

    always_comb begin
        d_exe = decode_dest(instr_exe);
        d_mem = decode_dest(instr_mem);
        d_wb  = decode_dest(instr_wb);
    end

    assign ws_exe        = d_exe.ws;
    assign we_bypass_exe = d_exe.alu_wr;
    assign we_stall_exe  = d_exe.late_wr;
    assign we_exe        = d_exe.alu_wr | d_exe.late_wr;
    assign ws_mem        = d_mem.ws;
    assign we_mem        = d_mem.alu_wr | d_mem.late_wr;
    assign ws_wb         = d_wb.ws;
    assign we_wb         = d_wb.alu_wr | d_wb.late_wr;

endmodule

// File: tb/tb_pipe_reg_usage_decoder.sv
// Directed, table-driven bench for pipe_reg_usage_decoder, with hand-written
// sequences for reset behaviour and the asynchronous reset pulse.
module tb_pipe_reg_usage_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_id;
    logic        stall, flush;
    logic        re1_id, re2_id;
    logic [4:0]  ws_exe, ws_mem, ws_wb;
    logic        we_exe, we_bypass_exe, we_stall_exe, we_mem, we_wb;
    logic [31:0] instr_exe, instr_mem, instr_wb;

    int checks = 0;
    int passes = 0;

    pipe_reg_usage_decoder dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .stall(stall), .flush(flush),
        .re1_id(re1_id), .re2_id(re2_id),
        .ws_exe(ws_exe), .we_exe(we_exe), .we_bypass_exe(we_bypass_exe), .we_stall_exe(we_stall_exe),
        .ws_mem(ws_mem), .we_mem(we_mem), .ws_wb(ws_wb), .we_wb(we_wb),
        .instr_exe(instr_exe), .instr_mem(instr_mem), .instr_wb(instr_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        stall;
        logic        flush;
        logic        re1;
        logic        re2;
        logic [4:0]  ws;
        logic        we;
        logic        byp;
        logic        stl;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic s, input logic f);
        instr_id = instr;
        stall    = s;
        flush    = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, " we_exe"}, 32'(we_exe), 32'd0);
        checkOutput({tag, " we_mem"}, 32'(we_mem), 32'd0);
        checkOutput({tag, " we_wb"},  32'(we_wb),  32'd0);
        checkOutput({tag, " ws_all"}, 32'({ws_exe, ws_mem, ws_wb}), 32'd0);
        checkOutput({tag, " byp_stl"}, 32'({we_bypass_exe, we_stall_exe}), 32'd0);
    endtask

    logic [4:0]  p1_ws, p2_ws;
    logic        p1_we, p2_we;
    logic [31:0] p1_i, p2_i, exp_i;

    initial begin
        //          instr         stl   fl    re1   re2   ws     we    byp   stl
        vecs[0]  = '{32'h00221820, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  1'b1, 1'b1, 1'b0}; // add $3,$1,$2
        vecs[1]  = '{32'h8C250004, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b1}; // lw $5,4($1)
        vecs[2]  = '{32'h0C000010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b1}; // jal
        vecs[3]  = '{32'h20200005, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0}; // addi $0
        vecs[4]  = '{32'h00221820, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0}; // stall
        vecs[5]  = '{32'h00221820, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0}; // flush
        vecs[6]  = '{32'h00221820, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0}; // both
        vecs[7]  = '{32'hAC220000, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0}; // sw
        vecs[8]  = '{32'h10220003, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0}; // beq
        vecs[9]  = '{32'h03E00008, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0}; // jr $31
        vecs[10] = '{32'h344700FF, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0}; // ori $7,$2,0xff
        vecs[11] = '{32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0}; // j
        vecs[12] = '{32'hFC000000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0}; // undefined
        vecs[13] = '{32'h00220020, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0}; // add $0,$1,$2

        rst = 1'b1;
        applyStimulus(32'h00221820, 1'b0, 1'b0);
        step();
        step();
        checkAllIdle("reset");
        checkOutput("reset instr_exe", instr_exe, 32'd0);

        #2 rst = 1'b0;
        applyStimulus(32'd0, 1'b0, 1'b0);
        step();
        step();
        checkAllIdle("post-reset idle");

        p1_ws = '0; p2_ws = '0; p1_we = 1'b0; p2_we = 1'b0; p1_i = '0; p2_i = '0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].instr, vecs[i].stall, vecs[i].flush);
            #1;
            checkOutput($sformatf("v%0d re1_id", i), 32'(re1_id), 32'(vecs[i].re1));
            checkOutput($sformatf("v%0d re2_id", i), 32'(re2_id), 32'(vecs[i].re2));
            step();
            exp_i = (vecs[i].stall | vecs[i].flush) ? 32'd0 : vecs[i].instr;
            checkOutput($sformatf("v%0d instr_exe", i), instr_exe, exp_i);
            checkOutput($sformatf("v%0d ws_exe", i), 32'(ws_exe), 32'(vecs[i].ws));
            checkOutput($sformatf("v%0d we_exe", i), 32'(we_exe), 32'(vecs[i].we));
            checkOutput($sformatf("v%0d we_bypass_exe", i), 32'(we_bypass_exe), 32'(vecs[i].byp));
            checkOutput($sformatf("v%0d we_stall_exe", i), 32'(we_stall_exe), 32'(vecs[i].stl));
            checkOutput($sformatf("v%0d instr_mem", i), instr_mem, p1_i);
            checkOutput($sformatf("v%0d ws_mem", i), 32'(ws_mem), 32'(p1_ws));
            checkOutput($sformatf("v%0d we_mem", i), 32'(we_mem), 32'(p1_we));
            checkOutput($sformatf("v%0d instr_wb", i), instr_wb, p2_i);
            checkOutput($sformatf("v%0d ws_wb", i), 32'(ws_wb), 32'(p2_ws));
            checkOutput($sformatf("v%0d we_wb", i), 32'(we_wb), 32'(p2_we));
            p2_ws = p1_ws; p2_we = p1_we; p2_i = p1_i;
            p1_ws = vecs[i].ws; p1_we = vecs[i].we; p1_i = exp_i;
        end

        // Fill EXE and MEM with writers, then pulse reset between clock edges.
        applyStimulus(32'h00221820, 1'b0, 1'b0);
        step();
        step();
        checkOutput("pre-async we_exe", 32'(we_exe), 32'd1);
        checkOutput("pre-async we_mem", 32'(we_mem), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkAllIdle("async reset");
        rst = 1'b0;
        #1;
        checkAllIdle("async reset released");
        step();
        checkOutput("resume ws_exe", 32'(ws_exe), 32'd3);
        checkOutput("resume we_mem", 32'(we_mem), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
